i2s_rx_slave: RTL
=================

Name: i2s_rx_slave

Overview:
- I2S receiver at the consuming end of the serial audio link, clocked by MCLK.
- Samples externally supplied SCLK, LRCLK and SDATA through synchronisers and detects SCLK rising edges in the MCLK domain.
- Deserialises left/right slots (Philips I2S: MSB one SCLK after the LRCLK transition, LRCLK low = left).
- Presents stereo frames on a valid/ready handshake to the downstream audio path.

Parameters:
- DATA_WIDTH, 24: captured bits per channel (MSB-first); bits beyond this in a slot are ignored.
- SYNC_STAGES, 2: flip-flop synchroniser depth on SCLK, LRCLK and SDATA (min 2).

Ports:
- MCLK  input  1  system clock; all logic on posedge; MCLK >= 4x SCLK.
- reset  input  1  asynchronous active-low reset; 0 = reset, released synchronously by the integrator.
- SCLK  input  1  external bit clock, asynchronous to MCLK.
- LRCLK  input  1  external word select, changes on SCLK falling edge; 0 = left, 1 = right.
- SDATA  input  1  serial data, changes on SCLK falling edge.
- left_data  output  DATA_WIDTH  left sample of the presented frame.
- right_data  output  DATA_WIDTH  right sample of the presented frame.
- frame_valid  output  1  frame on left_data/right_data is valid.
- frame_ready  input  1  downstream accepts the frame when frame_valid && frame_ready.
- overrun  output  1  sticky: a completed frame was dropped because the output was still held.
- short_slot  output  1  one-MCLK pulse: LRCLK changed before DATA_WIDTH bits were captured.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All synchroniser and edge flops are cleared to 0.
  - bit_cnt = 0, shift register = 0, left/right holding registers = 0.
  - left_data = 0, right_data = 0, frame_valid = 0, overrun = 0, short_slot = 0.
  - state = HUNT.
- Synchronisation and edge detection:
  - SCLK, LRCLK and SDATA each pass through SYNC_STAGES flops.
  - sclk_rise = synced SCLK = 1 while the previous synced SCLK = 0.
  - All capture actions occur only in MCLK cycles where sclk_rise = 1.
  - On each sclk_rise, ws_prev <= synced LRCLK.
- ws_change = synced LRCLK != ws_prev on an sclk_rise. The bit sampled on that rise is the previous slot's LSB and is not captured.
- States:
  - HUNT: waits for a ws_change to LRCLK = 0 (start of left slot), then -> LEFT with bit_cnt = 0. A ws_change to 1 is ignored, so a right slot is never paired with an unseen left.
  - LEFT / RIGHT, on each sclk_rise without ws_change while bit_cnt < DATA_WIDTH:
    - shift <= {shift[DATA_WIDTH-2:0], SDATA_sync}; bit_cnt++.
    - When bit_cnt becomes DATA_WIDTH, copy shift to the left (or right) holding register and set a slot_done flag.
    - Further rises in the slot are ignored (bit_cnt saturates).
  - ws_change in LEFT to 1 -> RIGHT, bit_cnt = 0. ws_change in RIGHT to 0 -> LEFT, bit_cnt = 0.
  - If either ws_change occurs with slot_done = 0: short_slot pulses for that cycle, the partial word is discarded and the state -> HUNT. A change to 0 from RIGHT instead goes straight to LEFT, because that edge is itself a valid left start.
- Frame completion: on the MCLK cycle after the right word is latched, with a complete left word latched in the same frame:
  - If frame_valid = 0, or frame_valid && frame_ready in that cycle: left_data/right_data load, frame_valid = 1.
  - Else the frame is dropped, outputs are unchanged, overrun <= 1 and stays set until reset.
- Handshake:
  - frame_valid falls the cycle after frame_valid && frame_ready, unless a new frame loads in that same cycle.
  - Outputs are stable while frame_valid && !frame_ready.
- Latency: right LSB SCLK rise at the pin -> frame_valid high in at most SYNC_STAGES + 3 MCLK cycles.
- Any SCLK/LRCLK ratio with at least DATA_WIDTH + 1 SCLK per slot is supported. No slot-length upper bound.

Test Plan:
- Stimulus common to all scenarios:
  - DATA_WIDTH = 24, SCLK = MCLK/8, 32 SCLK per slot, frame_ready tied 1.
  - Send left 0xA5A5A5, right 0x3C3C3C.
- Basic frame: standard stimulus -> left_data = 0xA5A5A5, right_data = 0x3C3C3C, frame_valid high 1 cycle, then repeats every 512 MCLK.
- Start in a right slot: release reset mid-right-slot -> no frame until after the first full left+right pair, and short_slot stays 0.
- Backpressure: frame_ready = 0 for 2 frames, then 1 -> first frame held stable, overrun = 1, second frame dropped, frame_valid drops after the accept.
- Short slot: LRCLK toggles after 10 bits of the left slot -> short_slot pulses once, no frame emitted for that pair, the next complete pair is received correctly.
- Reset mid-frame: assert reset during the right slot -> all outputs 0 immediately; after release, capture resumes only at the next left start.
- DATA_WIDTH = 16, 16-bit words 0x8001/0x7FFE in 32-bit slots -> exact values captured, trailing slot bits ignored.

Source files
------------

// File: rtl/i2s_rx_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_slave
// Description : Philips I2S receiver (slave). Synchronises external SCLK,
//               LRCLK and SDATA into the MCLK domain, deserialises the left
//               and right slots and presents complete stereo frames on a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_slave #(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  LRCLK,
    input  logic                  SDATA,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun,
    output logic                  short_slot
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    localparam logic [1:0] c_hunt  = 2'd0;
    localparam logic [1:0] c_left  = 2'd1;
    localparam logic [1:0] c_right = 2'd2;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ws_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_sclk_prev;
    logic                   r_ws_prev;

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [DATA_WIDTH-1:0]  r_left_hold;
    logic [DATA_WIDTH-1:0]  r_right_hold;
    logic                   r_slot_done;
    logic                   r_left_ok;
    logic                   r_frame_pend;

    logic                   w_sclk;
    logic                   w_ws;
    logic                   w_sd;
    logic                   w_sclk_rise;
    logic                   w_ws_change;
    logic                   w_capture;
    logic [DATA_WIDTH-1:0]  w_shift_next;

    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_ws         = r_ws_sync[SYNC_STAGES-1];
    assign w_sd         = r_sd_sync[SYNC_STAGES-1];
    assign w_sclk_rise  = w_sclk & ~r_sclk_prev;
    // The bit on a word-select change rise is the previous slot's LSB.
    assign w_ws_change  = w_sclk_rise & (w_ws != r_ws_prev);
    // Bits past DATA_WIDTH in a slot are ignored (counter saturates).
    assign w_capture    = w_sclk_rise & ~w_ws_change & (r_state != c_hunt)
                          & (r_bit_cnt != c_cnt_full);
    assign w_shift_next = {r_shift[DATA_WIDTH-2:0], w_sd};

    // Multi-flop synchronisers for the three asynchronous serial inputs.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_ws_sync   <= '0;
            r_sd_sync   <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], LRCLK};
            r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], SDATA};
        end
    end

    // SCLK edge history and word-select value seen on the last SCLK rise.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            r_sclk_prev <= 1'b0;
            r_ws_prev   <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk;
            if (w_sclk_rise) begin
                r_ws_prev <= w_ws;
            end
        end
    end

    // Slot tracking FSM and deserialiser; latches each completed word.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            r_state      <= c_hunt;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_slot_done  <= 1'b0;
            r_left_ok    <= 1'b0;
            r_frame_pend <= 1'b0;
            short_slot   <= 1'b0;
        end else begin
            short_slot   <= 1'b0;
            r_frame_pend <= 1'b0;
            if (w_ws_change) begin
                r_bit_cnt   <= '0;
                r_shift     <= '0;
                r_slot_done <= 1'b0;
                case (r_state)
                    c_hunt: begin
                        // Only a left start may begin a frame.
                        if (!w_ws) begin
                            r_state   <= c_left;
                            r_left_ok <= 1'b0;
                        end
                    end
                    c_left: begin
                        if (w_ws) begin
                            if (r_slot_done) begin
                                r_state <= c_right;
                            end else begin
                                short_slot <= 1'b1;
                                r_state    <= c_hunt;
                                r_left_ok  <= 1'b0;
                            end
                        end
                    end
                    c_right: begin
                        // A change to left is a valid left start even when
                        // the right word was short.
                        if (!w_ws) begin
                            if (!r_slot_done) begin
                                short_slot <= 1'b1;
                            end
                            r_state   <= c_left;
                            r_left_ok <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= c_hunt;
                        r_left_ok <= 1'b0;
                    end
                endcase
            end else if (w_capture) begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= r_bit_cnt + c_cnt_one;
                if (r_bit_cnt == c_cnt_last) begin
                    r_slot_done <= 1'b1;
                    if (r_state == c_left) begin
                        r_left_hold <= w_shift_next;
                        r_left_ok   <= 1'b1;
                    end else begin
                        r_right_hold <= w_shift_next;
                        r_frame_pend <= r_left_ok;
                    end
                end
            end
        end
    end

    // Output register with valid/ready handshake and sticky overrun.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            left_data   <= '0;
            right_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (r_frame_pend) begin
            if (!frame_valid || frame_ready) begin
                left_data   <= r_left_hold;
                right_data  <= r_right_hold;
                frame_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
